// File: rtl/axis_slave_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_slave_rx_fifo_if
//  Description : Beat-level handshake bundle for the AXI-Stream receive FIFO.
//                It carries the upstream backend beat interface (bk_*) and
//                the downstream AXI-Stream-style master port (m_*).
//                  slave  : view of the FIFO itself (consumes bk_*, drives m_*)
//                  master : view of the surrounding logic (drives bk_*,
//                           consumes m_*)
//  Revision    : 1.0  initial release
// ============================================================================
interface axis_slave_rx_fifo_if;
   logic [31:0] bk_data;
   logic [3:0]  bk_tstrb;
   logic [3:0]  bk_tkeep;
   logic [1:0]  bk_user;
   logic        bk_tlast;
   logic        bk_valid;
   logic        bk_ready;

   logic [31:0] m_tdata;
   logic [3:0]  m_tstrb;
   logic [3:0]  m_tkeep;
   logic [1:0]  m_tuser;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready;

   modport slave (
      input  bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
      output bk_ready,
      output m_tdata, m_tstrb, m_tkeep, m_tuser, m_tlast, m_tvalid,
      input  m_tready
   );

   modport master (
      output bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
      input  bk_ready,
      input  m_tdata, m_tstrb, m_tkeep, m_tuser, m_tlast, m_tvalid,
      output m_tready
   );
endinterface
`default_nettype wire

// File: rtl/axis_slave_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axis_slave_rx_fifo
//  Description : DEPTH-entry first-word-fall-through receive buffer behind
//                the AXI-Stream slave front end. Tracks buffered complete
//                packets and flags upstream overflow.
//  Ports       : axi_aclk  - clock
//                axi_reset - synchronous active-high reset
//                bus       - bk_* beat input / m_* stream output (slave view)
//                level     - stored beats, 0..DEPTH
//                pkt_cnt   - stored beats carrying tlast
//                ovf_err   - sticky overflow flag
//                clr_err   - clears ovf_err
//  Revision    : 1.0  initial release
// ============================================================================
module axis_slave_rx_fifo #(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  wire logic             axi_aclk,
   input  wire logic             axi_reset,
   axis_slave_rx_fifo_if.slave   bus,
   output logic      [PTR_W:0]   level,
   output logic      [PTR_W:0]   pkt_cnt,
   output logic                  ovf_err,
   input  wire logic             clr_err
);

   localparam int               c_entry_w = 43;
   localparam logic [PTR_W:0]   c_full    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

   logic [c_entry_w-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]     r_wr_ptr;
   logic [PTR_W-1:0]     r_rd_ptr;
   logic [PTR_W:0]       r_count;
   logic [PTR_W:0]       r_pkt_cnt;
   logic                 r_ovf_err;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_push_acc;
   logic                 w_push_drop;
   logic                 w_pop;
   logic                 w_tvalid;
   logic                 w_pkt_inc;
   logic                 w_pkt_dec;
   logic [c_entry_w-1:0] w_head;

   assign w_full  = (r_count == c_full);
   assign w_empty = (r_count == '0);

   // Upstream derives bk_valid from bk_ready, so bk_ready must come only
   // from registers (and reset) to avoid a combinational loop.
   assign bus.bk_ready = ~w_full & ~axi_reset;

   assign w_push      = bus.bk_valid & ~axi_reset;
   assign w_push_acc  = w_push & ~w_full;
   // A beat offered while full is a protocol violation: drop it, flag it.
   assign w_push_drop = w_push & w_full;

   assign w_tvalid     = ~w_empty & ~axi_reset;
   assign bus.m_tvalid = w_tvalid;
   assign w_pop        = w_tvalid & bus.m_tready;

   // Fall-through head; payload is zeroed whenever nothing is presented.
   assign w_head = w_tvalid ? r_mem[r_rd_ptr] : '0;
   assign {bus.m_tlast, bus.m_tuser, bus.m_tkeep, bus.m_tstrb, bus.m_tdata} = w_head;

   assign w_pkt_inc = w_push_acc & bus.bk_tlast;
   assign w_pkt_dec = w_pop & bus.m_tlast;

   assign level   = r_count;
   assign pkt_cnt = r_pkt_cnt;
   assign ovf_err = r_ovf_err;

   // Storage carries no reset; stale entries are never presented because
   // m_tvalid depends on the count alone.
   always_ff @(posedge axi_aclk) begin
      if (w_push_acc) begin
         r_mem[r_wr_ptr] <= {bus.bk_tlast, bus.bk_user, bus.bk_tkeep,
                             bus.bk_tstrb, bus.bk_data};
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_pkt_cnt <= '0;
         r_ovf_err <= 1'b0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)      r_rd_ptr <= r_rd_ptr + c_ptr_one;

         case ({w_push_acc, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase

         case ({w_pkt_inc, w_pkt_dec})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + c_cnt_one;
            2'b01:   r_pkt_cnt <= r_pkt_cnt - c_cnt_one;
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase

         // A new violation wins over a simultaneous clear.
         if (w_push_drop)  r_ovf_err <= 1'b1;
         else if (clr_err) r_ovf_err <= 1'b0;
      end
   end

endmodule
`default_nettype wire
